// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// pll_reset_sequencer
//
// Runs in the PLL output clock domain. It turns the raw, asynchronous PLL lock
// flag into a clean, registered, active-low synchronous reset for all logic
// clocked by the PLL output.
//
// Reset is released only after lock has stayed high for STABLE_CYCLES
// consecutive cycles. It is then held low for a further RESET_HOLD_CYCLES.
// Any loss of lock forces reset low again. A loss that happens after release
// sets a sticky status flag.
//
// Optional feature (compile-time macro PLL_LOSS_COUNT_EN):
//   When defined, the loss_count port and a saturating counter of
//   RUN -> WAIT_LOCK events are added. When undefined, both are absent and
//   all other behaviour is identical.
//
// Parameters:
//   STABLE_CYCLES      cycles lock must stay high before the hold starts (>=1)
//   RESET_HOLD_CYCLES  cycles sresetn_out stays low once lock is stable (>=1)
//   LOSS_CNT_WIDTH     width of loss_count (only used with PLL_LOSS_COUNT_EN)
//
// Ports:
//   clk               in   PLL output clock
//   aresetn           in   async active-low reset, clears all state
//   locked_async      in   raw PLL LOCK, asynchronous to clk
//   clear_sticky      in   single-cycle pulse, clears sticky flag / loss count
//   sresetn_out       out  registered sync active-low reset for downstream
//   ready             out  high while in RUN
//   lock_lost_sticky  out  set on any lock loss while in RUN
//   loss_count        out  saturating lock-loss count (PLL_LOSS_COUNT_EN only)
// ============================================================================
module pll_reset_sequencer #(
    parameter int STABLE_CYCLES     = 256,
    parameter int RESET_HOLD_CYCLES = 16,
    parameter int LOSS_CNT_WIDTH    = 8
) (
    input  logic clk,
    input  logic aresetn,
    input  logic locked_async,
    input  logic clear_sticky,
    output logic sresetn_out,
    output logic ready,
    output logic lock_lost_sticky
`ifdef PLL_LOSS_COUNT_EN
    ,
    output logic [LOSS_CNT_WIDTH-1:0] loss_count
`endif
);

    // The STABILIZE and HOLD phases never overlap, so they share one counter
    // sized for the longer of the two.
    localparam int CNT_MAX = (STABLE_CYCLES > RESET_HOLD_CYCLES) ? STABLE_CYCLES
                                                                  : RESET_HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lock_meta, locked_sync;
    logic             lock_loss;

    // ------------------------------------------------------------------------
    // Two-flop synchronizer. Nothing else in the design may read
    // locked_async directly.
    // NOTE: sequential state uses non-blocking (<=) assignments. Every flop
    // therefore samples its pre-edge value, which is what makes the
    // two-stage chain behave as two stages.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            lock_meta   <= 1'b0;
            locked_sync <= 1'b0;
        end else begin
            lock_meta   <= locked_async;
            locked_sync <= lock_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic.
    // NOTE: every output of this block is given a default first. A path that
    // leaves a variable unassigned would otherwise infer a latch.
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lock_loss = 1'b0;
        unique case (state)
            WAIT_LOCK: begin
                if (locked_sync) begin
                    state_nxt = STABILIZE;
                    cnt_nxt   = '0;
                end
            end
            STABILIZE: begin
                if (!locked_sync) begin
                    // The counter is re-zeroed on the next entry from WAIT_LOCK.
                    state_nxt = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!locked_sync) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == HOLD_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!locked_sync) begin
                    state_nxt = WAIT_LOCK;
                    lock_loss = 1'b1;
                end
            end
            default: state_nxt = WAIT_LOCK;
        endcase
    end

    // ------------------------------------------------------------------------
    // State, counter and registered outputs. The outputs are decoded from
    // state_nxt, so they change on the same edge as the state itself.
    // A new loss takes priority over clear_sticky.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state            <= WAIT_LOCK;
            cnt              <= '0;
            sresetn_out      <= 1'b0;
            ready            <= 1'b0;
            lock_lost_sticky <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sresetn_out <= (state_nxt == RUN);
            ready       <= (state_nxt == RUN);
            if (lock_loss)
                lock_lost_sticky <= 1'b1;
            else if (clear_sticky)
                lock_lost_sticky <= 1'b0;
        end
    end

`ifdef PLL_LOSS_COUNT_EN
    // Saturating loss counter. A clear and a loss on the same cycle leave
    // exactly one recorded loss.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            loss_count <= '0;
        end else if (lock_loss) begin
            if (clear_sticky)
                loss_count <= LOSS_CNT_WIDTH'(1);
            else if (loss_count != '1)
                loss_count <= loss_count + LOSS_CNT_WIDTH'(1);
        end else if (clear_sticky) begin
            loss_count <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ============================================================================
// tb_pll_reset_sequencer
//
// Directed bench for pll_reset_sequencer with STABLE_CYCLES=8,
// RESET_HOLD_CYCLES=4 and LOSS_CNT_WIDTH=2. The expected release latency is
// 8 + 4 + 3 = 15 rising edges. loss_count is checked only when
// PLL_LOSS_COUNT_EN is defined.
//
// Timing: inputs are driven and outputs sampled 1 ns after each rising edge.
// ============================================================================
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

    localparam int STABLE  = 8;
    localparam int HOLD    = 4;
    localparam int LATENCY = STABLE + HOLD + 3;   // 15 edges
    localparam int LCW     = 2;

    logic clk = 1'b0;
    logic aresetn;
    logic locked_async;
    logic clear_sticky;
    logic sresetn_out;
    logic ready;
    logic lock_lost_sticky;
`ifdef PLL_LOSS_COUNT_EN
    logic [LCW-1:0] loss_count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    pll_reset_sequencer #(
        .STABLE_CYCLES    (STABLE),
        .RESET_HOLD_CYCLES(HOLD),
        .LOSS_CNT_WIDTH   (LCW)
    ) dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .locked_async    (locked_async),
        .clear_sticky    (clear_sticky),
        .sresetn_out     (sresetn_out),
        .ready           (ready),
        .lock_lost_sticky(lock_lost_sticky)
`ifdef PLL_LOSS_COUNT_EN
        ,
        .loss_count      (loss_count)
`endif
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 ns.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bring the DUT to RUN from WAIT_LOCK with a steady lock.
    task automatic drive_to_run();
        locked_async = 1'b1;
        repeat (LATENCY) tick();
    endtask

    // Drop lock and wait until the loss has been seen by the FSM.
    task automatic drop_lock();
        locked_async = 1'b0;
        repeat (3) tick();
    endtask

    // Reset held with lock high: every output stays low.
    task automatic test_reset();
        aresetn      = 1'b0;
        locked_async = 1'b1;
        clear_sticky = 1'b0;
        #2;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if ({sresetn_out, ready, lock_lost_sticky} !== 3'b000)
                $display("FAIL reset_cycle%0d: {sresetn,ready,sticky}=%b expected 000",
                         i, {sresetn_out, ready, lock_lost_sticky});
            else
                n_pass++;
        end
`ifdef PLL_LOSS_COUNT_EN
        n_total++;
        if (loss_count !== 2'd0)
            $display("FAIL reset_loss_count: got %0d expected 0", loss_count);
        else
            n_pass++;
`endif
    endtask

    // Release with lock already high: sresetn_out rises exactly on edge 15.
    task automatic test_release_latency();
        aresetn = 1'b1;
        repeat (LATENCY - 1) tick();
        n_total++;
        if (sresetn_out !== 1'b0 || ready !== 1'b0)
            $display("FAIL release_edge14: sresetn=%b ready=%b expected 0 0", sresetn_out, ready);
        else
            n_pass++;
        tick();
        n_total++;
        if (sresetn_out !== 1'b1 || ready !== 1'b1)
            $display("FAIL release_edge15: sresetn=%b ready=%b expected 1 1", sresetn_out, ready);
        else
            n_pass++;
        n_total++;
        if (lock_lost_sticky !== 1'b0)
            $display("FAIL release_sticky: got %b expected 0", lock_lost_sticky);
        else
            n_pass++;
    endtask

    // Lock loss in RUN: outputs drop on the 3rd edge and the sticky flag sets.
    task automatic test_lock_loss();
        locked_async = 1'b0;
        repeat (2) tick();
        n_total++;
        if (sresetn_out !== 1'b1)
            $display("FAIL loss_edge2: sresetn=%b expected 1", sresetn_out);
        else
            n_pass++;
        tick();
        n_total++;
        if ({sresetn_out, ready, lock_lost_sticky} !== 3'b001)
            $display("FAIL loss_edge3: {sresetn,ready,sticky}=%b expected 001",
                     {sresetn_out, ready, lock_lost_sticky});
        else
            n_pass++;
`ifdef PLL_LOSS_COUNT_EN
        n_total++;
        if (loss_count !== 2'd1)
            $display("FAIL loss_count_first: got %0d expected 1", loss_count);
        else
            n_pass++;
`endif
    endtask

    // A glitch during STABILIZE restarts the count. Release then comes 15
    // edges after lock returns high.
    task automatic test_stabilize_glitch();
        locked_async = 1'b1;
        repeat (6) tick();          // STABILIZE entered on edge 3, counter mid-way
        locked_async = 1'b0;
        repeat (3) tick();
        locked_async = 1'b1;
        repeat (LATENCY - 1) tick();
        n_total++;
        if (sresetn_out !== 1'b0)
            $display("FAIL glitch_edge14: sresetn=%b expected 0", sresetn_out);
        else
            n_pass++;
        tick();
        n_total++;
        if (sresetn_out !== 1'b1 || ready !== 1'b1)
            $display("FAIL glitch_edge15: sresetn=%b ready=%b expected 1 1", sresetn_out, ready);
        else
            n_pass++;
        // A loss before release must not have touched the sticky flag
        // (it is still set from the earlier RUN loss).
        n_total++;
        if (lock_lost_sticky !== 1'b1)
            $display("FAIL glitch_sticky: got %b expected 1", lock_lost_sticky);
        else
            n_pass++;
    endtask

    // clear_sticky behaviour: lone clear, clear inside RUN, and clear on the
    // same edge as a loss.
    task automatic test_clear_sticky();
        // Lone clear while in RUN: sticky clears, sresetn stays high.
        clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
        n_total++;
        if (lock_lost_sticky !== 1'b0 || sresetn_out !== 1'b1)
            $display("FAIL clear_in_run: sticky=%b sresetn=%b expected 0 1",
                     lock_lost_sticky, sresetn_out);
        else
            n_pass++;
`ifdef PLL_LOSS_COUNT_EN
        n_total++;
        if (loss_count !== 2'd0)
            $display("FAIL clear_in_run_count: got %0d expected 0", loss_count);
        else
            n_pass++;
`endif
        // Clear coincident with the loss edge: set wins.
        locked_async = 1'b0;
        repeat (2) tick();
        clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
        n_total++;
        if (lock_lost_sticky !== 1'b1 || sresetn_out !== 1'b0)
            $display("FAIL clear_with_loss: sticky=%b sresetn=%b expected 1 0",
                     lock_lost_sticky, sresetn_out);
        else
            n_pass++;
`ifdef PLL_LOSS_COUNT_EN
        n_total++;
        if (loss_count !== 2'd1)
            $display("FAIL clear_with_loss_count: got %0d expected 1", loss_count);
        else
            n_pass++;
`endif
        // A later lone pulse clears everything.
        tick();
        clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
        n_total++;
        if (lock_lost_sticky !== 1'b0)
            $display("FAIL clear_later: sticky=%b expected 0", lock_lost_sticky);
        else
            n_pass++;
`ifdef PLL_LOSS_COUNT_EN
        n_total++;
        if (loss_count !== 2'd0)
            $display("FAIL clear_later_count: got %0d expected 0", loss_count);
        else
            n_pass++;
`endif
    endtask

    // Five RUN losses back to back: a 2-bit count saturates at 3.
    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            drive_to_run();
            n_total++;
            if (ready !== 1'b1)
                $display("FAIL b2b_run%0d: ready=%b expected 1", i, ready);
            else
                n_pass++;
            drop_lock();
        end
        n_total++;
        if ({sresetn_out, ready, lock_lost_sticky} !== 3'b001)
            $display("FAIL b2b_final: {sresetn,ready,sticky}=%b expected 001",
                     {sresetn_out, ready, lock_lost_sticky});
        else
            n_pass++;
`ifdef PLL_LOSS_COUNT_EN
        n_total++;
        if (loss_count !== 2'd3)
            $display("FAIL b2b_saturate: got %0d expected 3", loss_count);
        else
            n_pass++;
`endif
    endtask

    // aresetn asserted mid-RUN clears the outputs without waiting for an edge.
    task automatic test_async_reset();
        drive_to_run();
        #2;
        aresetn = 1'b0;
        #1;
        n_total++;
        if ({sresetn_out, ready, lock_lost_sticky} !== 3'b000)
            $display("FAIL async_reset: {sresetn,ready,sticky}=%b expected 000",
                     {sresetn_out, ready, lock_lost_sticky});
        else
            n_pass++;
        tick();
        aresetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_release_latency();
        test_lock_loss();
        test_stabilize_glitch();
        test_clear_sticky();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
